mmio_bus_ctrl: RTL and testbench

Parametrised memory-mapped I/O bus controller for the single-cycle CPU top level. It replaces the fixed address decoder and the tri-state read-data bus with a registered request/acknowledge transaction engine. It provides one-hot slave selects for N peripherals, per-slave wait-state support via ready handshakes, a muxed and registered read path, and a sticky bus-error register with a captured fault address. It sits between the CPU data port (ALU address / store data / write enable) and the peripheral interfaces: memory, LED, switch, button, segment, UART and VGA.

---
 rtl/mmio_bus_ctrl_pkg.sv | 18 +
 rtl/mmio_bus_ctrl_if.sv | 40 ++++
 rtl/mmio_bus_ctrl_timeout_ctr.sv | 29 ++
 rtl/mmio_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared types and helpers for the MMIO bus controller: FSM state encoding,
// slave-index width helper and the value returned on faulted reads.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned ERR_RDATA = 0;

    // Width of the slave index field; never below one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// CPU-side and peripheral-side transaction signals of the MMIO bus controller.
// master: CPU / peripheral model view; slave: controller view.
interface mmio_bus_ctrl_if
    import mmio_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 8
);
    localparam int SEL_W = sel_w(N_SLAVES);

    logic                         cpu_req;
    logic                         cpu_we;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic                         cpu_ack;
    logic [DATA_W-1:0]            cpu_rdata;

    logic [N_SLAVES-1:0]          slv_sel;
    logic                         slv_we;
    logic [ADDR_W-SEL_W-1:0]      slv_addr;
    logic [DATA_W-1:0]            slv_wdata;
    logic [N_SLAVES*DATA_W-1:0]   slv_rdata;
    logic [N_SLAVES-1:0]          slv_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  slv_sel, slv_we, slv_addr, slv_wdata,
        output slv_rdata, slv_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output slv_sel, slv_we, slv_addr, slv_wdata,
        input  slv_rdata, slv_ready
    );

endinterface

// File: rtl/mmio_bus_ctrl_timeout_ctr.sv
// 8-bit saturating wait counter for the ACCESS state; expired flags the
// edge on which the LIMIT-th consecutive ACCESS cycle completes.
module mmio_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic clear,
    input  logic en,
    output logic expired
);
    logic [7:0] wait_cnt_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt_reg <= 8'd0;
        end else if (start || clear) begin
            wait_cnt_reg <= 8'd0;
        end else if (en && (wait_cnt_reg != 8'hFF)) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end

    // Count holds the number of ACCESS edges already passed, so the edge
    // about to close cycle LIMIT sees LIMIT-1.
    assign expired = en && (wait_cnt_reg >= 8'(LIMIT - 1));

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Registered request/acknowledge MMIO bus controller with one-hot selects,
// ready-based wait states and sticky bus error. Timeout abort: MMIO_TIMEOUT_EN.
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset,
    mmio_bus_ctrl_if.slave    bus,
    input  logic              err_clr,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int SEL_W = sel_w(N_SLAVES);
    localparam int OFF_W = ADDR_W - SEL_W;
    localparam int N_PAD = 1 << SEL_W;

    generate
        if (N_SLAVES < 2 || N_SLAVES > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
            $error("mmio_bus_ctrl: N_SLAVES or TIMEOUT out of range");
        end
    endgenerate

    state_t              state_reg;
    logic [SEL_W-1:0]    idx_reg;
    logic                cpu_ack_reg;
    logic [DATA_W-1:0]   cpu_rdata_reg;
    logic [N_SLAVES-1:0] slv_sel_reg;
    logic                slv_we_reg;
    logic [OFF_W-1:0]    slv_addr_reg;
    logic [DATA_W-1:0]   slv_wdata_reg;
    logic                bus_err_reg;
    logic [ADDR_W-1:0]   err_addr_reg;

    logic [SEL_W-1:0]        req_idx;
    logic                    req_unmapped;
    logic [N_PAD-1:0]        ready_pad;
    logic [N_PAD*DATA_W-1:0] rdata_pad;
    logic                    sel_ready;
    logic [DATA_W-1:0]       sel_rdata;
    logic                    timeout_hit;
    logic                    may_load_addr;

    assign req_idx       = bus.cpu_addr[ADDR_W-1 -: SEL_W];
    assign req_unmapped  = (32'(req_idx) >= N_SLAVES);
    assign may_load_addr = !bus_err_reg || err_clr;

    // Pad to a power of two so the latched index can never select past the end.
    always_comb begin
        ready_pad = '0;
        ready_pad[N_SLAVES-1:0] = bus.slv_ready;
        rdata_pad = '0;
        rdata_pad[N_SLAVES*DATA_W-1:0] = bus.slv_rdata;
        sel_ready = ready_pad[idx_reg];
        sel_rdata = rdata_pad[idx_reg*DATA_W +: DATA_W];
    end

`ifdef MMIO_TIMEOUT_EN
    mmio_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset   (reset),
        .start   ((state_reg == IDLE) && bus.cpu_req && !req_unmapped),
        .clear   (state_reg == DONE),
        .en      (state_reg == ACCESS),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cpu_ack_reg   <= 1'b0;
            cpu_rdata_reg <= '0;
            slv_sel_reg   <= '0;
            slv_we_reg    <= 1'b0;
            slv_addr_reg  <= '0;
            slv_wdata_reg <= '0;
            bus_err_reg   <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            cpu_ack_reg <= 1'b0;
            // A fault raised below on the same edge overrides this clear.
            if (err_clr) begin
                bus_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.cpu_req) begin
                        idx_reg       <= req_idx;
                        slv_addr_reg  <= bus.cpu_addr[OFF_W-1:0];
                        slv_wdata_reg <= bus.cpu_wdata;
                        if (req_unmapped) begin
                            cpu_rdata_reg <= DATA_W'(ERR_RDATA);
                            bus_err_reg   <= 1'b1;
                            if (may_load_addr) begin
                                err_addr_reg <= bus.cpu_addr;
                            end
                            state_reg <= DONE;
                        end else begin
                            slv_sel_reg <= N_SLAVES'(N_PAD'(1) << req_idx);
                            slv_we_reg  <= bus.cpu_we;
                            state_reg   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        cpu_rdata_reg <= slv_we_reg ? DATA_W'(ERR_RDATA) : sel_rdata;
                        slv_sel_reg   <= '0;
                        slv_we_reg    <= 1'b0;
                        state_reg     <= DONE;
                    end else if (timeout_hit) begin
                        cpu_rdata_reg <= DATA_W'(ERR_RDATA);
                        bus_err_reg   <= 1'b1;
                        if (may_load_addr) begin
                            err_addr_reg <= {idx_reg, slv_addr_reg};
                        end
                        slv_sel_reg <= '0;
                        slv_we_reg  <= 1'b0;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    cpu_ack_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_reg;
    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.slv_sel   = slv_sel_reg;
    assign bus.slv_we    = slv_we_reg;
    assign bus.slv_addr  = slv_addr_reg;
    assign bus.slv_wdata = slv_wdata_reg;
    assign bus_err       = bus_err_reg;
    assign err_addr      = err_addr_reg;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl: an 8-slave instance (A) for timing, wait
// states, timeout and reset, and a 6-slave instance (B) for unmapped faults.
module tb_mmio_bus_ctrl;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic err_clr_a = 1'b0, err_clr_b = 1'b0;
    logic bus_err_a, bus_err_b;
    logic [ADDR_W-1:0] err_addr_a, err_addr_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mmio_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(8)) bus_a ();
    mmio_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(6)) bus_b ();

    mmio_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(8), .TIMEOUT(TIMEOUT)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a),
        .err_clr(err_clr_a), .bus_err(bus_err_a), .err_addr(err_addr_a)
    );

    mmio_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(6), .TIMEOUT(TIMEOUT)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b),
        .err_clr(err_clr_b), .bus_err(bus_err_b), .err_addr(err_addr_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        bus_a.cpu_req = 1'b1; bus_a.cpu_we = we; bus_a.cpu_addr = addr; bus_a.cpu_wdata = wd;
    endtask

    task automatic req_b(input logic [ADDR_W-1:0] addr);
        bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = addr; bus_b.cpu_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.cpu_req = 0; bus_a.cpu_we = 0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
        bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
        bus_a.slv_ready = 8'hFF;
        bus_b.slv_ready = 6'h3F;
        for (int i = 0; i < 8; i++) bus_a.slv_rdata[i*DATA_W +: DATA_W] = 32'hA000_0000 + i;
        bus_a.slv_rdata[3*DATA_W +: DATA_W] = 32'h1234_5678;
        for (int i = 0; i < 6; i++) bus_b.slv_rdata[i*DATA_W +: DATA_W] = 32'hB000_0000 + i;

        // Reset state
        step(); step();
        chk("rst_ack", bus_a.cpu_ack, 0);
        chk("rst_rdata", bus_a.cpu_rdata, 0);
        chk("rst_sel", bus_a.slv_sel, 0);
        chk("rst_we", bus_a.slv_we, 0);
        chk("rst_err", bus_err_a, 0);
        chk("rst_erraddr", err_addr_a, 0);
        reset = 1'b1;
        step();
        $display("txn reset: outputs checked");

        // Zero-wait read of slave 3
        req_a(1'b0, 10'h180, '0);
        step();                                   // E0
        chk("zw_sel_e0", bus_a.slv_sel, 8'h08);
        chk("zw_ack_e0", bus_a.cpu_ack, 0);
        step();                                   // E1
        chk("zw_sel_e1", bus_a.slv_sel, 8'h00);
        chk("zw_ack_e1", bus_a.cpu_ack, 0);
        step();                                   // E2
        chk("zw_ack_e2", bus_a.cpu_ack, 1);
        chk("zw_rdata", bus_a.cpu_rdata, 32'h1234_5678);
        bus_a.cpu_req = 1'b0;
        step();                                   // E3
        chk("zw_ack_e3", bus_a.cpu_ack, 0);
        chk("zw_rdata_hold", bus_a.cpu_rdata, 32'h1234_5678);
        $display("txn zero-wait read addr=0x180 rdata=0x%08h", bus_a.cpu_rdata);

        // Write with four wait states; other slaves ready but must be ignored
        bus_a.slv_ready = 8'hFD;
        req_a(1'b1, 10'h080, 32'h0000_00A5);
        step();                                   // E0
        chk("ws_sel_e0", bus_a.slv_sel, 8'h02);
        chk("ws_we_e0", bus_a.slv_we, 1);
        chk("ws_wdata", bus_a.slv_wdata, 32'hA5);
        chk("ws_addr", bus_a.slv_addr, 0);
        for (int k = 1; k <= 4; k++) begin
            step();                               // E1..E4
            chk("ws_sel_hold", {bus_a.slv_sel, bus_a.slv_we, bus_a.cpu_ack}, {8'h02, 1'b1, 1'b0});
        end
        bus_a.slv_ready = 8'hFF;
        step();                                   // E5
        chk("ws_sel_e5", bus_a.slv_sel, 0);
        chk("ws_ack_e5", bus_a.cpu_ack, 0);
        step();                                   // E6
        chk("ws_ack_e6", bus_a.cpu_ack, 1);
        chk("ws_rdata", bus_a.cpu_rdata, 0);
        chk("ws_err", bus_err_a, 0);
        bus_a.cpu_req = 1'b0;
        step();
        $display("txn wait-state write addr=0x080 wdata=0xA5 ack after E6");

`ifdef MMIO_TIMEOUT_EN
        // Timeout on slave 2
        bus_a.slv_ready = 8'hFB;
        req_a(1'b0, 10'h100, '0);
        step();                                   // E0
        chk("to_sel_e0", bus_a.slv_sel, 8'h04);
        for (int k = 1; k <= 14; k++) step();     // E1..E14
        chk("to_sel_e14", {bus_a.slv_sel, bus_a.cpu_ack}, {8'h04, 1'b0});
        step();                                   // E15
        chk("to_sel_e15", bus_a.slv_sel, 0);
        step();                                   // E16
        chk("to_ack", bus_a.cpu_ack, 1);
        chk("to_rdata", bus_a.cpu_rdata, 0);
        chk("to_err", bus_err_a, 1);
        chk("to_erraddr", err_addr_a, 10'h100);
        bus_a.cpu_req = 1'b0;
        step();
        $display("txn timeout read addr=0x100 err_addr=0x%0h", err_addr_a);

        // Second fault keeps the first address
        req_a(1'b0, 10'h101, '0);
        for (int k = 0; k < 40 && !bus_a.cpu_ack; k++) step();
        chk("to2_ack", bus_a.cpu_ack, 1);
        chk("to2_erraddr", err_addr_a, 10'h100);
        bus_a.cpu_req = 1'b0;
        err_clr_a = 1'b1;
        step();
        err_clr_a = 1'b0;
        chk("to_clr", bus_err_a, 0);
        $display("txn second timeout addr=0x101 then err_clr");

        // Ready on the timeout edge wins
        req_a(1'b0, 10'h100, '0);
        step();                                   // E0
        for (int k = 1; k <= 14; k++) step();     // E1..E14
        bus_a.slv_ready = 8'hFF;
        step();                                   // E15
        chk("col_sel", bus_a.slv_sel, 0);
        chk("col_err_e15", bus_err_a, 0);
        step();                                   // E16
        chk("col_ack", bus_a.cpu_ack, 1);
        chk("col_rdata", bus_a.cpu_rdata, 32'hA000_0002);
        chk("col_err", bus_err_a, 0);
        bus_a.cpu_req = 1'b0;
        step();
        $display("txn ready/timeout collision rdata=0x%08h", bus_a.cpu_rdata);
`else
        // Without timeout the access waits for ready indefinitely
        bus_a.slv_ready = 8'hFB;
        req_a(1'b0, 10'h100, '0);
        step();
        chk("nt_sel_e0", bus_a.slv_sel, 8'h04);
        for (int k = 1; k <= 20; k++) step();
        chk("nt_wait", {bus_a.slv_sel, bus_a.cpu_ack, bus_err_a}, {8'h04, 1'b0, 1'b0});
        bus_a.slv_ready = 8'hFF;
        step();
        chk("nt_sel_done", bus_a.slv_sel, 0);
        step();
        chk("nt_ack", bus_a.cpu_ack, 1);
        chk("nt_rdata", bus_a.cpu_rdata, 32'hA000_0002);
        chk("nt_err", bus_err_a, 0);
        bus_a.cpu_req = 1'b0;
        step();
        $display("txn long wait read addr=0x100 rdata=0x%08h", bus_a.cpu_rdata);
`endif

        // Unmapped index 7 on the 6-slave instance
        req_b(10'h380);
        step();                                   // E0
        chk("um_sel", bus_b.slv_sel, 0);
        chk("um_ack_e0", bus_b.cpu_ack, 0);
        chk("um_err", bus_err_b, 1);
        chk("um_erraddr", err_addr_b, 10'h380);
        step();                                   // E1
        chk("um_ack_e1", bus_b.cpu_ack, 1);
        chk("um_rdata", bus_b.cpu_rdata, 0);
        bus_b.cpu_req = 1'b0;
        step();
        $display("txn unmapped addr=0x380 err_addr=0x%0h", err_addr_b);

        req_b(10'h300);                           // idx 6, second fault
        step(); step();
        chk("um2_ack", bus_b.cpu_ack, 1);
        chk("um2_erraddr", err_addr_b, 10'h380);
        bus_b.cpu_req = 1'b0;
        step();
        $display("txn unmapped addr=0x300 err_addr held");

        req_b(10'h3C0);                           // fault on the clear edge
        err_clr_b = 1'b1;
        step();
        err_clr_b = 1'b0;
        chk("um3_err", bus_err_b, 1);
        chk("um3_erraddr", err_addr_b, 10'h3C0);
        step();
        bus_b.cpu_req = 1'b0;
        err_clr_b = 1'b1;
        step();
        err_clr_b = 1'b0;
        chk("um_clr", bus_err_b, 0);
        $display("txn unmapped on err_clr edge addr=0x3C0");

        req_b(10'h280);                           // highest mapped slave 5
        step();
        chk("b5_sel", bus_b.slv_sel, 6'h20);
        step(); step();
        chk("b5_rdata", {bus_b.cpu_ack, bus_b.cpu_rdata}, {1'b1, 32'hB000_0005});
        bus_b.cpu_req = 1'b0;
        step();
        $display("txn mapped read slave5 rdata=0x%08h", bus_b.cpu_rdata);

        // Reset in the middle of an access
        bus_a.slv_ready = 8'h00;
        req_a(1'b1, 10'h1FF, 32'hDEAD_BEEF);
        step();
        chk("ra_sel", bus_a.slv_sel, 8'h08);
        step(); step();
        reset = 1'b0;
        bus_a.cpu_req = 1'b0;
        step();
        reset = 1'b1;
        chk("ra_outs", {bus_a.slv_sel, bus_a.slv_we, bus_a.cpu_ack, bus_err_a},
            {8'h00, 1'b0, 1'b0, 1'b0});
        chk("ra_rdata", bus_a.cpu_rdata, 0);
        chk("ra_addr", bus_a.slv_addr, 0);
        chk("ra_wdata", bus_a.slv_wdata, 0);
        chk("ra_erraddr", err_addr_a, 0);
        step(); step();
        chk("ra_noack", bus_a.cpu_ack, 0);
        bus_a.slv_ready = 8'hFF;
        req_a(1'b0, 10'h180, '0);
        step(); step(); step();
        chk("ra_next_ack", bus_a.cpu_ack, 1);
        chk("ra_next_rdata", bus_a.cpu_rdata, 32'h1234_5678);
        bus_a.cpu_req = 1'b0;
        step();
        $display("txn reset mid-access then read rdata=0x%08h", bus_a.cpu_rdata);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
